// File: rtl/id_ex_decode_if.sv
// ID/EX channel between the decode stage (master) and the execute stage (slave).
// Valid/ready handshake plus the registered ALU operands and control fields.
interface id_ex_decode_if #(
   parameter int XLEN = 64
);
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] ex_src_a;
   logic [XLEN-1:0] ex_src_b;
   logic [3:0]      ex_alu_ctrl;
   logic [XLEN-1:0] ex_imm;
   logic [XLEN-1:0] ex_pc;
   logic [4:0]      ex_rd;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic            ex_reg_write;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            ex_branch;
   logic            ex_illegal;

   modport master (
      output out_valid, ex_src_a, ex_src_b, ex_alu_ctrl, ex_imm, ex_pc,
             ex_rd, ex_rs1, ex_rs2, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_branch, ex_illegal,
      input  out_ready
   );

   modport slave (
      input  out_valid, ex_src_a, ex_src_b, ex_alu_ctrl, ex_imm, ex_pc,
             ex_rd, ex_rs1, ex_rs2, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_branch, ex_illegal,
      output out_ready
   );
endinterface

// File: rtl/id_ex_decode.sv
// RV64I+Zba decode stage with the ID/EX pipeline register feeding the EX-stage ALU.
// One-entry skid-free register: accepts a new instruction whenever the current entry leaves.
module id_ex_decode #(
   parameter int XLEN           = 64,
   parameter bit ILLEGAL_AS_NOP = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   id_ex_decode_if.master  ex,
   output logic            illegal_o
);

   localparam logic [3:0] ALU_ADD      = 4'b0000;
   localparam logic [3:0] ALU_SUB      = 4'b0001;
   localparam logic [3:0] ALU_AND      = 4'b0010;
   localparam logic [3:0] ALU_OR       = 4'b0011;
   localparam logic [3:0] ALU_SH1ADD   = 4'b0100;
   localparam logic [3:0] ALU_SH2ADD   = 4'b0101;
   localparam logic [3:0] ALU_SH3ADD   = 4'b0110;
   localparam logic [3:0] ALU_ADD_UW   = 4'b0111;
   localparam logic [3:0] ALU_SH1ADDUW = 4'b1000;
   localparam logic [3:0] ALU_SH2ADDUW = 4'b1001;
   localparam logic [3:0] ALU_SH3ADDUW = 4'b1010;
   localparam logic [3:0] ALU_SLLI_UW  = 4'b1011;

   logic [6:0] opcode_p0;
   logic [2:0] f3_p0;
   logic [6:0] f7_p0;
   logic [4:0] rd_p0;

   logic signed [11:0]     imm12_i_p0;
   logic signed [11:0]     imm12_s_p0;
   logic signed [12:0]     imm13_b_p0;
   logic signed [XLEN-1:0] imm_i_p0;
   logic signed [XLEN-1:0] imm_s_p0;
   logic signed [XLEN-1:0] imm_b_p0;

   logic [3:0]      alu_ctrl_p0;
   logic [XLEN-1:0] src_b_p0;
   logic [XLEN-1:0] imm_p0;
   logic            legal_p0;
   logic            writes_rd_p0;
   logic            reg_write_p0;
   logic            mem_read_p0;
   logic            mem_write_p0;
   logic            branch_p0;
   logic            accept_p0;
   logic            capture_p0;

   logic            vld_p1;
   logic [XLEN-1:0] src_a_p1;
   logic [XLEN-1:0] src_b_p1;
   logic [3:0]      alu_ctrl_p1;
   logic [XLEN-1:0] imm_p1;
   logic [XLEN-1:0] pc_p1;
   logic [4:0]      rd_p1;
   logic [4:0]      rs1_p1;
   logic [4:0]      rs2_p1;
   logic            reg_write_p1;
   logic            mem_read_p1;
   logic            mem_write_p1;
   logic            branch_p1;
   logic            illegal_p1;
   logic            illegal_pulse_p1;

   // ---- p0: field extraction and immediate sign extension
   assign opcode_p0  = in_instr[6:0];
   assign rd_p0      = in_instr[11:7];
   assign f3_p0      = in_instr[14:12];
   assign f7_p0      = in_instr[31:25];
   assign imm12_i_p0 = in_instr[31:20];
   assign imm12_s_p0 = {in_instr[31:25], in_instr[11:7]};
   assign imm13_b_p0 = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_i_p0   = imm12_i_p0;
   assign imm_s_p0   = imm12_s_p0;
   assign imm_b_p0   = imm13_b_p0;

   always_comb begin
      alu_ctrl_p0  = ALU_ADD;
      src_b_p0     = rs2_data;
      imm_p0       = '0;
      legal_p0     = 1'b0;
      writes_rd_p0 = 1'b0;
      mem_read_p0  = 1'b0;
      mem_write_p0 = 1'b0;
      branch_p0    = 1'b0;
      case (opcode_p0)
         7'b0110011: begin
            writes_rd_p0 = 1'b1;
            case ({f7_p0, f3_p0})
               {7'b0000000, 3'b000}: begin alu_ctrl_p0 = ALU_ADD;    legal_p0 = 1'b1; end
               {7'b0000000, 3'b111}: begin alu_ctrl_p0 = ALU_AND;    legal_p0 = 1'b1; end
               {7'b0000000, 3'b110}: begin alu_ctrl_p0 = ALU_OR;     legal_p0 = 1'b1; end
               {7'b0100000, 3'b000}: begin alu_ctrl_p0 = ALU_SUB;    legal_p0 = 1'b1; end
               {7'b0010000, 3'b010}: begin alu_ctrl_p0 = ALU_SH1ADD; legal_p0 = 1'b1; end
               {7'b0010000, 3'b100}: begin alu_ctrl_p0 = ALU_SH2ADD; legal_p0 = 1'b1; end
               {7'b0010000, 3'b110}: begin alu_ctrl_p0 = ALU_SH3ADD; legal_p0 = 1'b1; end
               default: ;
            endcase
         end
         7'b0111011: begin
            writes_rd_p0 = 1'b1;
            case ({f7_p0, f3_p0})
               {7'b0000100, 3'b000}: begin alu_ctrl_p0 = ALU_ADD_UW;   legal_p0 = 1'b1; end
               {7'b0010000, 3'b010}: begin alu_ctrl_p0 = ALU_SH1ADDUW; legal_p0 = 1'b1; end
               {7'b0010000, 3'b100}: begin alu_ctrl_p0 = ALU_SH2ADDUW; legal_p0 = 1'b1; end
               {7'b0010000, 3'b110}: begin alu_ctrl_p0 = ALU_SH3ADDUW; legal_p0 = 1'b1; end
               default: ;
            endcase
         end
         7'b0010011: begin
            writes_rd_p0 = 1'b1;
            src_b_p0     = imm_i_p0;
            imm_p0       = imm_i_p0;
            case (f3_p0)
               3'b000:  begin alu_ctrl_p0 = ALU_ADD; legal_p0 = 1'b1; end
               3'b111:  begin alu_ctrl_p0 = ALU_AND; legal_p0 = 1'b1; end
               3'b110:  begin alu_ctrl_p0 = ALU_OR;  legal_p0 = 1'b1; end
               default: ;
            endcase
         end
         7'b0011011: begin
            writes_rd_p0 = 1'b1;
            // Shift amount is a 6-bit unsigned field, never sign-extended
            src_b_p0     = {{(XLEN-6){1'b0}}, in_instr[25:20]};
            imm_p0       = src_b_p0;
            if (f3_p0 == 3'b001 && in_instr[31:26] == 6'b000010) begin
               alu_ctrl_p0 = ALU_SLLI_UW;
               legal_p0    = 1'b1;
            end
         end
         7'b0000011: begin
            writes_rd_p0 = 1'b1;
            src_b_p0     = imm_i_p0;
            imm_p0       = imm_i_p0;
            if (f3_p0 == 3'b011) begin
               legal_p0    = 1'b1;
               mem_read_p0 = 1'b1;
            end
         end
         7'b0100011: begin
            src_b_p0 = imm_s_p0;
            imm_p0   = imm_s_p0;
            if (f3_p0 == 3'b011) begin
               legal_p0     = 1'b1;
               mem_write_p0 = 1'b1;
            end
         end
         7'b1100011: begin
            imm_p0 = imm_b_p0;
            if (f3_p0 == 3'b000) begin
               alu_ctrl_p0 = ALU_SUB;
               legal_p0    = 1'b1;
               branch_p0   = 1'b1;
            end
         end
         default: ;
      endcase
      if (!legal_p0) begin
         alu_ctrl_p0 = ALU_ADD;
      end
   end

   assign reg_write_p0 = legal_p0 && writes_rd_p0 && (rd_p0 != 5'd0);
   assign in_ready     = !vld_p1 || ex.out_ready;
   assign accept_p0    = in_valid && in_ready && !flush;
   // In NOP mode an illegal word is consumed but never becomes an EX entry
   assign capture_p0   = accept_p0 && (legal_p0 || !ILLEGAL_AS_NOP);

   // ---- p1: ID/EX register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1           <= 1'b0;
         illegal_pulse_p1 <= 1'b0;
         src_a_p1         <= '0;
         src_b_p1         <= '0;
         alu_ctrl_p1      <= ALU_ADD;
         imm_p1           <= '0;
         pc_p1            <= '0;
         rd_p1            <= '0;
         rs1_p1           <= '0;
         rs2_p1           <= '0;
         reg_write_p1     <= 1'b0;
         mem_read_p1      <= 1'b0;
         mem_write_p1     <= 1'b0;
         branch_p1        <= 1'b0;
         illegal_p1       <= 1'b0;
      end else begin
         illegal_pulse_p1 <= accept_p0 && !legal_p0;
         if (flush) begin
            vld_p1 <= 1'b0;
         end else if (in_ready) begin
            vld_p1 <= capture_p0;
            if (capture_p0) begin
               src_a_p1     <= rs1_data;
               src_b_p1     <= src_b_p0;
               alu_ctrl_p1  <= alu_ctrl_p0;
               imm_p1       <= imm_p0;
               pc_p1        <= in_pc;
               rd_p1        <= rd_p0;
               rs1_p1       <= in_instr[19:15];
               rs2_p1       <= in_instr[24:20];
               reg_write_p1 <= reg_write_p0;
               mem_read_p1  <= mem_read_p0;
               mem_write_p1 <= mem_write_p0;
               branch_p1    <= branch_p0;
               illegal_p1   <= !legal_p0;
            end
         end
      end
   end

   assign ex.out_valid    = vld_p1;
   assign ex.ex_src_a     = src_a_p1;
   assign ex.ex_src_b     = src_b_p1;
   assign ex.ex_alu_ctrl  = alu_ctrl_p1;
   assign ex.ex_imm       = imm_p1;
   assign ex.ex_pc        = pc_p1;
   assign ex.ex_rd        = rd_p1;
   assign ex.ex_rs1       = rs1_p1;
   assign ex.ex_rs2       = rs2_p1;
   assign ex.ex_reg_write = reg_write_p1;
   assign ex.ex_mem_read  = mem_read_p1;
   assign ex.ex_mem_write = mem_write_p1;
   assign ex.ex_branch    = branch_p1;
   assign ex.ex_illegal   = illegal_p1;
   assign illegal_o       = illegal_pulse_p1;

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed bench for id_ex_decode: decode table, immediates, handshake, flush and reset.
module tb_id_ex_decode;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic        illegal_o;

   int n_pass;
   int n_total;

   id_ex_decode_if #(.XLEN(64)) bus ();

   id_ex_decode #(.XLEN(64), .ILLEGAL_AS_NOP(1'b1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .in_pc    (in_pc),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .ex       (bus),
      .illegal_o(illegal_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [63:0] pc,
                        input logic [63:0] a, input logic [63:0] b);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      rs1_data = a;
      rs2_data = b;
   endtask

   task automatic test_reset();
      repeat (2) step();
      n_total++;
      if (bus.out_valid !== 1'b0 || illegal_o !== 1'b0 || bus.ex_alu_ctrl !== 4'b0000 ||
          bus.ex_src_a !== 64'd0 || bus.ex_reg_write !== 1'b0 || bus.ex_pc !== 64'd0)
         $display("FAIL reset_state got v=%b ill=%b ctrl=%b a=%h rw=%b pc=%h exp all zero",
                  bus.out_valid, illegal_o, bus.ex_alu_ctrl, bus.ex_src_a, bus.ex_reg_write, bus.ex_pc);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
      else n_pass++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add();
      bus.out_ready = 1'b1;
      drive(32'h002081B3, 64'h1000, 64'd5, 64'd7);
      step();
      in_valid = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_alu_ctrl !== 4'b0000 || bus.ex_src_a !== 64'd5 ||
          bus.ex_src_b !== 64'd7 || bus.ex_rd !== 5'd3 || bus.ex_reg_write !== 1'b1 ||
          bus.ex_pc !== 64'h1000 || bus.ex_rs1 !== 5'd1 || bus.ex_rs2 !== 5'd2)
         $display("FAIL add got v=%b ctrl=%b a=%0d b=%0d rd=%0d rw=%b pc=%h rs1=%0d rs2=%0d exp 1 0000 5 7 3 1 1000 1 2",
                  bus.out_valid, bus.ex_alu_ctrl, bus.ex_src_a, bus.ex_src_b, bus.ex_rd,
                  bus.ex_reg_write, bus.ex_pc, bus.ex_rs1, bus.ex_rs2);
      else n_pass++;
      step();
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL add_drain got v=%b exp 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_zba();
      drive(32'h2020C23B, 64'h1004, 64'hFFFF_FFFF_0000_0003, 64'h10);
      step();
      in_valid = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_alu_ctrl !== 4'b1001 ||
          bus.ex_src_a !== 64'hFFFF_FFFF_0000_0003 || bus.ex_src_b !== 64'h10 ||
          bus.ex_rd !== 5'd4 || bus.ex_reg_write !== 1'b1)
         $display("FAIL sh2add_uw got v=%b ctrl=%b a=%h b=%h rd=%0d rw=%b exp 1 1001 ffffffff00000003 10 4 1",
                  bus.out_valid, bus.ex_alu_ctrl, bus.ex_src_a, bus.ex_src_b, bus.ex_rd, bus.ex_reg_write);
      else n_pass++;
      step();
   endtask

   task automatic test_imm();
      drive(32'h0873129B, 64'h1008, 64'h55, 64'h99);
      step();
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_alu_ctrl !== 4'b1011 || bus.ex_src_b !== 64'd7 ||
          bus.ex_rd !== 5'd5 || bus.ex_src_a !== 64'h55 || bus.ex_reg_write !== 1'b1)
         $display("FAIL slli_uw got v=%b ctrl=%b b=%h rd=%0d a=%h rw=%b exp 1 1011 7 5 55 1",
                  bus.out_valid, bus.ex_alu_ctrl, bus.ex_src_b, bus.ex_rd, bus.ex_src_a, bus.ex_reg_write);
      else n_pass++;
      drive(32'hFFF00093, 64'h100C, 64'd0, 64'h1234);
      step();
      in_valid = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_alu_ctrl !== 4'b0000 || bus.ex_src_b !== 64'hFFFF_FFFF_FFFF_FFFF ||
          bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFFF || bus.ex_rd !== 5'd1 || bus.ex_reg_write !== 1'b1)
         $display("FAIL addi_neg got v=%b ctrl=%b b=%h imm=%h rd=%0d rw=%b exp 1 0000 all-ones all-ones 1 1",
                  bus.out_valid, bus.ex_alu_ctrl, bus.ex_src_b, bus.ex_imm, bus.ex_rd, bus.ex_reg_write);
      else n_pass++;
      step();
   endtask

   task automatic test_mem();
      drive(32'h0100B383, 64'h2000, 64'h100, 64'h77);
      step();
      n_total++;
      if (bus.ex_alu_ctrl !== 4'b0000 || bus.ex_src_b !== 64'd16 || bus.ex_mem_read !== 1'b1 ||
          bus.ex_mem_write !== 1'b0 || bus.ex_reg_write !== 1'b1 || bus.ex_rd !== 5'd7)
         $display("FAIL ld got ctrl=%b b=%h mr=%b mw=%b rw=%b rd=%0d exp 0000 10 1 0 1 7",
                  bus.ex_alu_ctrl, bus.ex_src_b, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_rd);
      else n_pass++;
      drive(32'hFE20BC23, 64'h2004, 64'h100, 64'h77);
      step();
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_src_b !== 64'hFFFF_FFFF_FFFF_FFF8 || bus.ex_mem_write !== 1'b1 ||
          bus.ex_mem_read !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_alu_ctrl !== 4'b0000)
         $display("FAIL sd got v=%b b=%h mw=%b mr=%b rw=%b ctrl=%b exp 1 fffffffffffffff8 1 0 0 0000",
                  bus.out_valid, bus.ex_src_b, bus.ex_mem_write, bus.ex_mem_read, bus.ex_reg_write, bus.ex_alu_ctrl);
      else n_pass++;
      drive(32'h00208033, 64'h2008, 64'd1, 64'd2);
      step();
      in_valid = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0)
         $display("FAIL add_x0 got v=%b rd=%0d rw=%b exp 1 0 0", bus.out_valid, bus.ex_rd, bus.ex_reg_write);
      else n_pass++;
      step();
   endtask

   task automatic test_illegal_nop();
      drive(32'h0000_0000, 64'h3000, 64'd1, 64'd1);
      step();
      n_total++;
      if (bus.out_valid !== 1'b0 || illegal_o !== 1'b1)
         $display("FAIL illegal_zero got v=%b ill=%b exp 0 1", bus.out_valid, illegal_o);
      else n_pass++;
      drive(32'h00208463, 64'h3004, 64'd9, 64'd9);
      step();
      n_total++;
      if (illegal_o !== 1'b0 || bus.out_valid !== 1'b1 || bus.ex_alu_ctrl !== 4'b0001 ||
          bus.ex_branch !== 1'b1 || bus.ex_reg_write !== 1'b0 || bus.ex_src_b !== 64'd9 ||
          bus.ex_imm !== 64'd8 || bus.ex_illegal !== 1'b0)
         $display("FAIL beq got ill=%b v=%b ctrl=%b br=%b rw=%b b=%0d imm=%h exill=%b exp 0 1 0001 1 0 9 8 0",
                  illegal_o, bus.out_valid, bus.ex_alu_ctrl, bus.ex_branch, bus.ex_reg_write,
                  bus.ex_src_b, bus.ex_imm, bus.ex_illegal);
      else n_pass++;
      drive(32'hFFFF_FFFF, 64'h3008, 64'd1, 64'd1);
      step();
      n_total++;
      if (bus.out_valid !== 1'b0 || illegal_o !== 1'b1)
         $display("FAIL illegal_ones got v=%b ill=%b exp 0 1", bus.out_valid, illegal_o);
      else n_pass++;
      drive(32'hFE000EE3, 64'h300C, 64'd0, 64'd0);
      step();
      in_valid = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC || illegal_o !== 1'b0)
         $display("FAIL beq_neg got v=%b imm=%h ill=%b exp 1 fffffffffffffffc 0",
                  bus.out_valid, bus.ex_imm, illegal_o);
      else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [3];
      logic [3:0]  ctl [3];
      ins = '{32'h002081B3, 32'h402081B3, 32'h2020A1B3};
      ctl = '{4'b0000, 4'b0001, 4'b0100};
      for (int i = 0; i < 3; i++) begin
         drive(ins[i], 64'h200 + 64'(4 * i), 64'(i + 20), 64'd3);
         step();
         n_total++;
         if (bus.out_valid !== 1'b1 || bus.ex_alu_ctrl !== ctl[i] ||
             bus.ex_pc !== 64'h200 + 64'(4 * i) || bus.ex_src_a !== 64'(i + 20))
            $display("FAIL b2b_%0d got v=%b ctrl=%b pc=%h a=%0d exp 1 %b %h %0d", i, bus.out_valid,
                     bus.ex_alu_ctrl, bus.ex_pc, bus.ex_src_a, ctl[i], 64'h200 + 64'(4 * i), i + 20);
         else n_pass++;
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      drive(32'h002081B3, 64'h300, 64'd1, 64'd2);
      step();
      bus.out_ready = 1'b0;
      drive(32'h402081B3, 64'h304, 64'd10, 64'd3);
      #1;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low got %b exp 0", in_ready);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if (bus.out_valid !== 1'b1 || bus.ex_pc !== 64'h300 || bus.ex_alu_ctrl !== 4'b0000 ||
             bus.ex_src_a !== 64'd1 || in_ready !== 1'b0)
            $display("FAIL bp_hold_%0d got v=%b pc=%h ctrl=%b a=%0d rdy=%b exp 1 300 0000 1 0",
                     i, bus.out_valid, bus.ex_pc, bus.ex_alu_ctrl, bus.ex_src_a, in_ready);
         else n_pass++;
      end
      bus.out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL bp_in_ready_high got %b exp 1", in_ready);
      else n_pass++;
      step();
      in_valid = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.ex_pc !== 64'h304 || bus.ex_alu_ctrl !== 4'b0001 ||
          bus.ex_src_a !== 64'd10)
         $display("FAIL bp_release got v=%b pc=%h ctrl=%b a=%0d exp 1 304 0001 10",
                  bus.out_valid, bus.ex_pc, bus.ex_alu_ctrl, bus.ex_src_a);
      else n_pass++;
      step();
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got v=%b exp 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_flush();
      drive(32'h002081B3, 64'h400, 64'd1, 64'd2);
      step();
      flush = 1'b1;
      drive(32'h402081B3, 64'h404, 64'd4, 64'd4);
      step();
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL flush_kill got v=%b exp 0", bus.out_valid);
      else n_pass++;
      drive(32'h0000_0000, 64'h408, 64'd0, 64'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      n_total++;
      if (illegal_o !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL flush_illegal got ill=%b v=%b exp 0 0", illegal_o, bus.out_valid);
      else n_pass++;
      step();
      n_total++;
      if (bus.out_valid !== 1'b0 || bus.ex_pc !== 64'h400)
         $display("FAIL flush_no_capture got v=%b pc=%h exp 0 400", bus.out_valid, bus.ex_pc);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      drive(32'h002081B3, 64'h500, 64'd1, 64'd2);
      step();
      in_valid      = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (bus.out_valid !== 1'b0 || bus.ex_pc !== 64'd0)
         $display("FAIL async_reset got v=%b pc=%h exp 0 0", bus.out_valid, bus.ex_pc);
      else n_pass++;
      #1;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      step();
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL async_reset_after got v=%b exp 0", bus.out_valid);
      else n_pass++;
   endtask

   initial begin
      n_pass        = 0;
      n_total       = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      in_valid      = 1'b0;
      in_instr      = '0;
      in_pc         = '0;
      rs1_data      = '0;
      rs2_data      = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_add();
      test_zba();
      test_imm();
      test_mem();
      test_illegal_nop();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
